// File: rtl/thor2024_bus_req_arbiter.sv
// ============================================================================
// Module      : thor2024_bus_req_arbiter
// Description : Round-robin, burst-locking arbiter that connects NREQ command
//               streams to one bus request queue. The optional lock timeout is
//               compiled in with THOR2024_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package thor2024_fta_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'd0,
      CTI_FIXED   = 3'd1,
      CTI_INCR    = 3'd2,
      CTI_EOB     = 3'd7
   } fta_cti_t;

   typedef struct packed {
      logic          cyc;
      logic          stb;
      logic          we;
      logic [15:0]   sel;
      fta_cti_t      cti;
      logic [31:0]   adr;
      logic [127:0]  dat;
   } fta_cmd_request128_t;

endpackage

module thor2024_bus_req_arbiter
   import thor2024_fta_pkg::*;
#(
   parameter int          NREQ    = 4,
   parameter logic [5:0]  TIMEOUT = 6'd32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  fta_cmd_request128_t  req_i [NREQ],
   output logic [NREQ-1:0]      full_o,
   output logic [NREQ-1:0]      gnt_o,
   output fta_cmd_request128_t  req_o,
   input  logic                 full_i,
   output logic                 busy_o
);

   localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PW-1:0]      r_rr_ptr;
   logic [c_PW-1:0]      r_gnt_idx;
   logic [NREQ-1:0]      r_gnt;
   logic [5:0]           r_gap;
   logic [3:0]           r_beat_cnt;

   logic [c_PW-1:0]      w_pick_idx;
   logic                 w_any_req;
   fta_cmd_request128_t  w_cur;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_timeout;
   logic                 w_release;

   // Scan downward so the lowest offset from the pointer wins.
   always_comb begin
      w_any_req  = 1'b0;
      w_pick_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[(int'(r_rr_ptr) + k) % NREQ].cyc) begin
            w_any_req  = 1'b1;
            w_pick_idx = c_PW'((int'(r_rr_ptr) + k) % NREQ);
         end
      end
   end

   assign w_cur    = req_i[r_gnt_idx];
   assign w_accept = (r_state == ST_LOCK) && w_cur.cyc && !full_i;
   assign w_last   = w_accept && ((w_cur.cti == CTI_EOB) || (w_cur.cti == CTI_CLASSIC));

`ifdef THOR2024_ARB_TIMEOUT_EN
   assign w_timeout = (r_state == ST_LOCK) && (r_gap == TIMEOUT);
`else
   assign w_timeout = 1'b0;
`endif

   assign w_release = w_last || w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req) w_state_nxt = ST_LOCK;
         ST_LOCK: if (w_release) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Only the granted stream sees the real queue status; everyone else is held off.
   always_comb begin
      req_o  = '0;
      full_o = '1;
      if (r_state == ST_LOCK) begin
         if (w_cur.cyc) req_o = w_cur;
         full_o[r_gnt_idx] = full_i;
      end
   end

   assign gnt_o  = r_gnt;
   assign busy_o = (r_state == ST_LOCK);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_gnt_idx  <= '0;
         r_gnt      <= '0;
         r_gap      <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
                  r_gnt_idx  <= w_pick_idx;
                  r_gap      <= '0;
                  r_beat_cnt <= '0;
               end
            end
            ST_LOCK: begin
               if (w_accept) begin
                  r_gap <= '0;
                  if (r_beat_cnt != 4'hF) r_beat_cnt <= r_beat_cnt + 4'd1;
               end else if (!w_cur.cyc && (r_gap != 6'd63)) begin
                  r_gap <= r_gap + 6'd1;
               end
               if (w_release) begin
                  r_gnt <= '0;
                  if (int'(r_gnt_idx) == NREQ - 1) r_rr_ptr <= '0;
                  else                             r_rr_ptr <= r_gnt_idx + c_PW'(1);
               end
            end
            default: r_gnt <= '0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_thor2024_bus_req_arbiter.sv
// ============================================================================
// Module      : tb_thor2024_bus_req_arbiter
// Description : Scoreboard bench for the burst-locking round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thor2024_bus_req_arbiter;
   import thor2024_fta_pkg::*;

   localparam int NREQ = 4;

   logic                 clk;
   logic                 rst;
   fta_cmd_request128_t  req_i [NREQ];
   logic [NREQ-1:0]      full_o;
   logic [NREQ-1:0]      gnt_o;
   fta_cmd_request128_t  req_o;
   logic                 full_i;
   logic                 busy_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [134:0] exp_q [$];

   thor2024_bus_req_arbiter #(.NREQ(NREQ), .TIMEOUT(6'd32)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_i),
      .full_o (full_o),
      .gnt_o  (gnt_o),
      .req_o  (req_o),
      .full_i (full_i),
      .busy_o (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic raise(input int r, input fta_cti_t cti, input logic [127:0] dat);
      req_i[r].cyc = 1'b1;
      req_i[r].stb = 1'b1;
      req_i[r].we  = 1'b1;
      req_i[r].sel = '1;
      req_i[r].cti = cti;
      req_i[r].adr = dat[31:0];
      req_i[r].dat = dat;
   endtask

   task automatic push(input int r, input fta_cti_t cti, input logic [127:0] dat);
      logic [3:0] oh;
      oh = 4'(1 << r);
      exp_q.push_back({oh, 3'(cti), dat});
   endtask

   task automatic present(input int r, input fta_cti_t cti, input logic [127:0] dat);
      raise(r, cti, dat);
      push(r, cti, dat);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at a negedge; returns at posedge+1 after the beat was taken.
   task automatic wait_accept(input int r);
      int n;
      n = 0;
      while (!(gnt_o[r] && !full_i) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 160'(n), 160'(0));
      step();
      req_i[r].cyc = 1'b0;
      req_i[r].stb = 1'b0;
   endtask

   task automatic beat(input int r, input fta_cti_t cti, input logic [127:0] dat);
      present(r, cti, dat);
      @(negedge clk);
      wait_accept(r);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         check("gap_busy", 160'(busy_o), 160'(1));
      end
      step();
   endtask

   function automatic logic [127:0] rdat();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Every accepted beat on the bus side must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && req_o.cyc && !full_i) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 160'(exp_q.size()), 160'(1));
         end else begin
            check("sb_beat", 160'({gnt_o, 3'(req_o.cti), req_o.dat}), 160'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] d;
      int cnt;
      rst    = 1'b1;
      full_i = 1'b0;
      for (int i = 0; i < NREQ; i++) req_i[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt",  160'(gnt_o),  160'(0));
      check("rst_busy", 160'(busy_o), 160'(0));
      check("rst_full", 160'(full_o), 160'(4'b1111));
      check("rst_reqo", 160'(req_o),  160'(0));
      step();
      rst = 1'b0;
      step();

      // Single requester 1, four beats with gaps
      present(1, CTI_FIXED, rdat());
      @(negedge clk);
      check("lat_gnt_n",   160'(gnt_o),  160'(0));
      check("lat_busy_n",  160'(busy_o), 160'(0));
      @(negedge clk);
      check("lat_gnt_n1",  160'(gnt_o),  160'(4'b0010));
      check("lat_full_n1", 160'(full_o), 160'(4'b1101));
      check("lat_busy_n1", 160'(busy_o), 160'(1));
      wait_accept(1);
      gap(2);
      beat(1, CTI_FIXED, rdat());
      gap(1);
      beat(1, CTI_FIXED, rdat());
      gap(3);
      beat(1, CTI_EOB, rdat());
      @(negedge clk);
      check("eob_busy", 160'(busy_o), 160'(0));
      check("eob_gnt",  160'(gnt_o),  160'(0));
      step();

      // rr_ptr is now 2: requester 3 beats 1; single CLASSIC beat releases
      present(3, CTI_CLASSIC, rdat());
      raise(1, CTI_FIXED, rdat());
      @(negedge clk);
      @(negedge clk);
      check("rr2_gnt",  160'(gnt_o),  160'(4'b1000));
      check("rr2_full", 160'(full_o), 160'(4'b0111));
      wait_accept(3);
      req_i[1].cyc = 1'b0;
      @(negedge clk);
      check("classic_busy", 160'(busy_o), 160'(0));
      step();

      // rr_ptr is now 0: requesters 0 and 2 together
      present(0, CTI_FIXED, rdat());
      raise(2, CTI_EOB, rdat());
      @(negedge clk);
      @(negedge clk);
      check("rr0_gnt",  160'(gnt_o),  160'(4'b0001));
      check("rr0_full", 160'(full_o), 160'(4'b1110));
      wait_accept(0);
      present(0, CTI_EOB, rdat());
      @(negedge clk);
      check("rr0_full2", 160'(full_o), 160'(4'b1110));
      wait_accept(0);
      d = req_i[2].dat;
      present(2, CTI_EOB, d);
      @(negedge clk);
      check("dead_gnt", 160'(gnt_o), 160'(0));
      @(negedge clk);
      check("next_gnt", 160'(gnt_o), 160'(4'b0100));
      wait_accept(2);

      // rr_ptr is 3: requester 2 wins after wrap; full_i stall mid-burst
      present(2, CTI_FIXED, rdat());
      @(negedge clk);
      @(negedge clk);
      check("wrap_gnt", 160'(gnt_o), 160'(4'b0100));
      wait_accept(2);
      d = rdat();
      present(2, CTI_INCR, d);
      full_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_dat",  160'(req_o.dat), 160'(d));
         check("stall_full", 160'(full_o),    160'(4'b1111));
         check("stall_busy", 160'(busy_o),    160'(1));
      end
      step();
      full_i = 1'b0;
      @(negedge clk);
      wait_accept(2);
      beat(2, CTI_EOB, rdat());

      // rr_ptr is 3: requester 3 goes silent after two beats while 0 waits
      present(3, CTI_FIXED, rdat());
      @(negedge clk);
      wait_accept(3);
      beat(3, CTI_FIXED, rdat());
      d = rdat();
`ifdef THOR2024_ARB_TIMEOUT_EN
      present(0, CTI_FIXED, d);
      cnt = 0;
      while (!gnt_o[0] && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_cycles", 160'(cnt), 160'(35));
`else
      raise(0, CTI_FIXED, d);
      repeat (40) @(negedge clk);
      check("hold_gnt",  160'(gnt_o),  160'(4'b1000));
      check("hold_busy", 160'(busy_o), 160'(1));
      step();
      beat(3, CTI_EOB, rdat());
      push(0, CTI_FIXED, d);
      @(negedge clk);
      check("hold_dead", 160'(gnt_o), 160'(0));
      @(negedge clk);
      check("hold_next", 160'(gnt_o), 160'(4'b0001));
`endif
      wait_accept(0);

      // Reset during beat 3 of requester 0
      beat(0, CTI_FIXED, rdat());
      raise(0, CTI_FIXED, rdat());
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mrst_gnt",  160'(gnt_o),     160'(0));
      check("mrst_cyc",  160'(req_o.cyc), 160'(0));
      check("mrst_full", 160'(full_o),    160'(4'b1111));
      check("mrst_busy", 160'(busy_o),    160'(0));
      step();
      rst = 1'b0;
      req_i[0].cyc = 1'b0;
      step();
      check("sb_left", 160'(exp_q.size()), 160'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/thor2024_bus_req_arbiter.md
THOR2024_BUS_REQ_ARBITER -- requirements
Module: thor2024_bus_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 6'd32, maximum idle cycles inside a locked burst.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_i, input, NREQ x fta_cmd_request128_t, requester command streams.
REQ-006 SHALL have port full_o, input-side backpressure, output, NREQ, per-requester full.
REQ-007 SHALL have port gnt_o, output, NREQ, one-hot grant.
REQ-008 SHALL have port req_o, output, fta_cmd_request128_t, command to bus.
REQ-009 SHALL have port full_i, input, 1, bus request queue full.
REQ-010 SHALL have port busy_o, output, 1, arbiter holds a grant.

Function
REQ-011 SHALL request-detect requester i when req_i[i].cyc=1.
REQ-012 SHALL implement states IDLE and LOCK; reset state IDLE.
REQ-013 IDLE: if any request, SHALL grant the first requester at or after pointer rr_ptr (modulo NREQ), register gnt_o, enter LOCK next cycle; else stay IDLE.
REQ-014 Arbitration latency SHALL be one cycle: request at cycle N -> gnt_o valid at N+1.
REQ-015 In IDLE, full_o SHALL be all ones, gnt_o zero, req_o.cyc/stb zero.
REQ-016 In LOCK, req_o SHALL equal req_i[granted] combinationally when its cyc=1; otherwise req_o SHALL be cleared (cyc=stb=we=0, sel=0, cti=CLASSIC).
REQ-017 In LOCK, full_o[granted] SHALL equal full_i; all other full_o bits SHALL be 1.
REQ-018 Beat accepted SHALL mean LOCK and req_i[granted].cyc=1 and full_i=0.
REQ-019 Lock SHALL persist across cycles where the granted requester drops cyc (inter-beat gaps).
REQ-020 Lock SHALL release when an accepted beat has cti=EOB or cti=CLASSIC; next state IDLE.
REQ-021 On release, rr_ptr SHALL become (granted+1) modulo NREQ; no grant in the IDLE cycle after release (one dead cycle).
REQ-022 A 6-bit gap counter SHALL clear on each accepted beat and on grant, increment each LOCK cycle with granted cyc=0, saturate at 63.
REQ-023 Accepted beat count per grant SHALL be tracked (4-bit, saturating); busy_o=1 exactly in LOCK.
REQ-024 full_i held high SHALL stall the grant indefinitely; no release, no timeout (gap counter counts only cyc=0 cycles).
REQ-025 Requests appearing while LOCK SHALL wait; no preemption.

Reset
REQ-026 On rst: state IDLE, rr_ptr 0, gnt_o 0, gap counter 0, beat count 0, busy_o 0, req_o fields 0 with cti=CLASSIC, full_o all ones.
REQ-027 rst mid-burst SHALL abandon the lock the following cycle with no further beats forwarded.

Configuration
REQ-028 Macro THOR2024_ARB_TIMEOUT_EN defined: lock SHALL also release when gap counter reaches TIMEOUT, rr_ptr advanced per REQ-021.
REQ-029 Macro undefined: no timeout release; gap counter still maintained for debug; lock held until EOB/CLASSIC beat.

Verification
REQ-030 Single requester 1, four beats FIXED,FIXED,FIXED,EOB with cyc gaps, full_i=0 -> gnt_o=4'b0010 from N+1, four beats on req_o, busy_o drops after EOB beat, rr_ptr=2.
REQ-031 Requesters 0 and 2 assert at same cycle, rr_ptr=0 -> 0 granted; after its EOB, dead cycle, then 2 granted; full_o[2]=1 throughout 0's burst.
REQ-032 Granted requester, full_i=1 for 10 cycles mid-burst -> req_o holds beat, full_o[granted]=1, no release, beat accepted cycle full_i drops.
REQ-033 THOR2024_ARB_TIMEOUT_EN, TIMEOUT=32, requester drops cyc after beat 2 -> release after 32 gap cycles, next requester granted; undefined -> lock held.
REQ-034 rst asserted during beat 3 -> next cycle gnt_o=0, req_o.cyc=0, full_o all ones, state IDLE.
REQ-035 Single CLASSIC beat from requester 3 -> one accepted beat, immediate release, rr_ptr=0.
